// File: rtl/stoch_mm_sched_if.sv
// stoch_mm_sched_if: job, bitstream-source, multiplier and result signals of the stochastic matmul sequencer
//   slave  : sequencer side (stoch_mm_sched)
//   master : environment side (job issuer, bitstream generators, multiplier, result consumer)
//   start_valid/start_ready/stream_len : job request handshake and stream length
//   src_en/A_bits/B_bits               : bitstream generator enable and current bits
//   mm_nRST/mm_A/mm_B/mm_Y             : multiplier reset, operands and product bits
//   res_valid/res_ready/res_cnt        : per-element ones counts handshake, [i][j] row-major
//   busy                               : sequencer not idle
interface stoch_mm_sched_if #(
    parameter int NUM_ROWS = 2,
    parameter int NUM_MID  = 2,
    parameter int NUM_COLS = 2,
    parameter int LEN_W    = 10,
    parameter int CNT_W    = 10
);
    logic                               start_valid;
    logic                               start_ready;
    logic [LEN_W-1:0]                   stream_len;
    logic                               src_en;
    logic [NUM_ROWS*NUM_MID-1:0]        A_bits;
    logic [NUM_MID*NUM_COLS-1:0]        B_bits;
    logic                               mm_nRST;
    logic [NUM_ROWS*NUM_MID-1:0]        mm_A;
    logic [NUM_MID*NUM_COLS-1:0]        mm_B;
    logic [NUM_ROWS*NUM_COLS-1:0]       mm_Y;
    logic                               res_valid;
    logic                               res_ready;
    logic [NUM_ROWS*NUM_COLS*CNT_W-1:0] res_cnt;
    logic                               busy;

    modport slave (
        input  start_valid, stream_len, A_bits, B_bits, mm_Y, res_ready,
        output start_ready, src_en, mm_nRST, mm_A, mm_B, res_valid, res_cnt, busy
    );

    modport master (
        output start_valid, stream_len, A_bits, B_bits, mm_Y, res_ready,
        input  start_ready, src_en, mm_nRST, mm_A, mm_B, res_valid, res_cnt, busy
    );
endinterface

// File: rtl/stoch_mm_sched.sv
// stoch_mm_sched: job sequencer for a shared stochastic matrix multiplier
//   CLK   : clock, rising edge
//   RST   : asynchronous active-high reset
//   abort : (only with STOCH_MM_SCHED_ABORT_EN defined) drops a running job back to IDLE
//   bus   : stoch_mm_sched_if.slave - job handshake, generator gating, multiplier
//           operands/reset/products and per-element ones-count result handshake
// Sequence per job: IDLE -> CLEAR -> STREAM (len cycles) -> DRAIN (PIPE_DELAY cycles) -> DONE.
module stoch_mm_sched #(
    parameter int NUM_ROWS   = 2,
    parameter int NUM_MID    = 2,
    parameter int NUM_COLS   = 2,
    parameter int LEN_W      = 10,
    parameter int CNT_W      = 10,
    parameter int PIPE_DELAY = 1
) (
    input logic CLK,
    input logic RST,
`ifdef STOCH_MM_SCHED_ABORT_EN
    input logic abort,
`endif
    stoch_mm_sched_if.slave bus
);
    localparam int NE = NUM_ROWS * NUM_COLS;

    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q [NE];
    logic [CNT_W-1:0] cnt_d [NE];
    logic             accept, abort_hit, feed, feed_dly;

`ifdef STOCH_MM_SCHED_ABORT_EN
    assign abort_hit = abort && (state_q == CLEAR || state_q == STREAM || state_q == DRAIN);
`else
    assign abort_hit = 1'b0;
`endif

    assign accept = bus.start_valid && state_q == IDLE;
    assign feed   = state_q == STREAM && !abort_hit;

    // rem_q counts down the stream length, then is reloaded with the drain length
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d = CLEAR;
                rem_d   = bus.stream_len;
            end
            CLEAR: state_d = (rem_q != '0) ? STREAM : DONE;
            STREAM: if (rem_q == LEN_W'(1)) begin
                state_d = (PIPE_DELAY == 0) ? DONE : DRAIN;
                rem_d   = LEN_W'(PIPE_DELAY);
            end else begin
                rem_d = rem_q - LEN_W'(1);
            end
            DRAIN: if (rem_q == LEN_W'(1)) state_d = DONE;
                   else rem_d = rem_q - LEN_W'(1);
            DONE: if (bus.res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort_hit) state_d = IDLE;
    end

    // feed delayed by the multiplier latency marks which mm_Y samples belong to the job
    generate
        if (PIPE_DELAY == 0) begin : g_nodly
            assign feed_dly = feed;
        end else begin : g_dly
            logic [PIPE_DELAY-1:0] sr_q, sr_d;
            always_comb sr_d = abort_hit ? '0 : PIPE_DELAY'({sr_q, feed});
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) sr_q <= '0;
                else     sr_q <= sr_d;
            end
            assign feed_dly = sr_q[PIPE_DELAY-1];
        end
    endgenerate

    // saturating ones counters, zeroed when a job is accepted or aborted
    always_comb begin
        for (int k = 0; k < NE; k++)
            cnt_d[k] = (accept || abort_hit) ? '0 :
                       (feed_dly && bus.mm_Y[k] && cnt_q[k] != '1) ? cnt_q[k] + CNT_W'(1) : cnt_q[k];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            rem_q   <= '0;
            for (int k = 0; k < NE; k++) cnt_q[k] <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            for (int k = 0; k < NE; k++) cnt_q[k] <= cnt_d[k];
        end
    end

    assign bus.start_ready = state_q == IDLE;
    assign bus.busy        = state_q != IDLE;
    assign bus.src_en      = feed;
    assign bus.mm_nRST     = (state_q == STREAM || state_q == DRAIN) && !abort_hit;
    assign bus.mm_A        = feed ? bus.A_bits : {(NUM_ROWS*NUM_MID){1'b0}};
    assign bus.mm_B        = feed ? bus.B_bits : {(NUM_MID*NUM_COLS){1'b0}};
    assign bus.res_valid   = state_q == DONE;

    generate
        for (genvar e = 0; e < NE; e++) begin : g_pack
            assign bus.res_cnt[e*CNT_W +: CNT_W] = cnt_q[e];
        end
    endgenerate
endmodule
